// File: rtl/calc_pkg.sv
// calc_pkg: op codes, FSM states and operand conversion for calc_ctrl.
// Multiply support is selected by CALC_CTRL_MUL_EN.
package calc_pkg;

  localparam int OPW_D = 3;
  localparam int RW_D  = 2*OPW_D-1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_e;

  // Negating a zero magnitude yields zero, so -0 folds to +0.
  function automatic logic [RW_D-1:0] sm_to_tc(
    input logic [OPW_D-1:0] sm
  );
    logic [RW_D-1:0] mag;
    mag = RW_D'(sm[OPW_D-2:0]);
    return sm[OPW_D-1] ? -mag : mag;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: sign-magnitude multiply by repeated addition.
// Built only when CALC_CTRL_MUL_EN is defined.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int OPW = OPW_D,
  parameter int RW  = 2*OPW-1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_run,
  input  logic [OPW-2:0] i_a_mag,
  input  logic [OPW-2:0] i_b_mag,
  input  logic           i_sgn,
  output logic           o_done,
  output logic [RW-1:0]  o_result
);

  localparam logic [OPW-2:0] CNT_ONE = 1;

  logic [RW-1:0]  r_acc;
  logic [OPW-2:0] r_cnt;
  logic [OPW-2:0] r_b;
  logic           r_sgn;
  logic [RW-1:0]  w_b_ext;

  assign w_b_ext = RW'(r_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_b   <= '0;
      r_sgn <= 1'b0;
    end else if (i_start) begin
      r_acc <= '0;
      r_cnt <= i_a_mag;
      r_b   <= i_b_mag;
      r_sgn <= i_sgn;
    end else if (i_run && (r_cnt != '0)) begin
      r_acc <= r_acc + w_b_ext;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_done   = i_run && (r_cnt == '0);
  // A zero accumulator negates to zero, so the product is never -0.
  assign o_result = r_sgn ? -r_acc : r_acc;

endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencing controller for the signed calculator datapath.
// Define CALC_CTRL_MUL_EN to build the repeated-add multiplier.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int OPW = OPW_D,
  parameter int RW  = 2*OPW-1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [OPW-1:0] req_a,
  input  logic [OPW-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [RW-1:0]  rsp_result,
  output logic           rsp_err
);

  state_e         r_state;
  state_e         w_next;
  logic [1:0]     r_op;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [RW-1:0]  r_result;
  logic           r_err;
  logic           r_rsp_valid;

  logic           w_accept;
  logic           w_hs;
  logic [RW-1:0]  w_ta;
  logic [RW-1:0]  w_tb;
  logic [RW-1:0]  w_exec_res;
  logic           w_exec_err;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_hs     = (r_state == S_DONE) && r_rsp_valid && rsp_ready;

`ifdef CALC_CTRL_MUL_EN
  logic          w_mul_done;
  logic [RW-1:0] w_mul_res;

  calc_mul_seq #(
    .OPW(OPW),
    .RW (RW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_accept),
    .i_run   (r_state == S_MUL),
    .i_a_mag (req_a[OPW-2:0]),
    .i_b_mag (req_b[OPW-2:0]),
    .i_sgn   (req_a[OPW-1] ^ req_b[OPW-1]),
    .o_done  (w_mul_done),
    .o_result(w_mul_res)
  );
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef CALC_CTRL_MUL_EN
          w_next = (req_op == OP_MUL) ? S_MUL : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_DONE;
      S_MUL: begin
`ifdef CALC_CTRL_MUL_EN
        if (w_mul_done) w_next = S_DONE;
`else
        w_next = S_IDLE;
`endif
      end
      S_DONE: begin
        if (w_hs) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ta = sm_to_tc(r_a);
  assign w_tb = sm_to_tc(r_b);

  always_comb begin
    w_exec_res = '0;
    w_exec_err = 1'b0;
    unique case (1'b1)
      (r_op == OP_ADD): w_exec_res = w_ta + w_tb;
      (r_op == OP_SUB): w_exec_res = w_ta - w_tb;
      (r_op == OP_NEG): w_exec_res = -w_ta;
      (r_op == OP_MUL): begin
`ifdef CALC_CTRL_MUL_EN
        w_exec_res = '0;
`else
        w_exec_err = 1'b1;
`endif
      end
      default: w_exec_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= req_op;
        r_a  <= req_a;
        r_b  <= req_b;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_exec_res;
        r_err    <= w_exec_err;
      end
`ifdef CALC_CTRL_MUL_EN
      if ((r_state == S_MUL) && w_mul_done) begin
        r_result <= w_mul_res;
        r_err    <= 1'b0;
      end
`endif
      // Response goes valid one cycle after the result lands.
      if ((r_state == S_DONE) && !r_rsp_valid) begin
        r_rsp_valid <= 1'b1;
      end else if (w_hs) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: scoreboard bench for calc_ctrl with an integer model.
// Honours CALC_CTRL_MUL_EN the same way as the design.
module tb_calc_ctrl;

  localparam int OPW = 3;
  localparam int RW  = 5;
  localparam int NRAND = 200;

  typedef struct {
    logic [RW-1:0] res;
    logic          err;
    int            at_e;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
    int         stall;
    bit         do_rst;
  } dreq_t;

  logic           clk;
  logic           rst;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [OPW-1:0] req_a;
  logic [OPW-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [RW-1:0]  rsp_result;
  logic           rsp_err;

  calc_ctrl #(.OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_err   (rsp_err)
  );

  int   checks = 0;
  int   errors = 0;
  int   e = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit   active = 0;
  bit   hs_pend = 0;
  dreq_t dir[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    e++;
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, want, e);
    end
  endtask

  function automatic int smv(input logic [2:0] x);
    int m;
    m = int'(x[1:0]);
    return x[2] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [2:0] a,
                                 input logic [2:0] b, input int acc_e);
    exp_t m;
    int   r;
    int   lat;
    r   = 0;
    lat = 2;
    m.err = 1'b0;
    case (op)
      2'b00: r = smv(a) + smv(b);
      2'b01: r = smv(a) - smv(b);
      2'b11: r = -smv(a);
      default: begin
`ifdef CALC_CTRL_MUL_EN
        r   = smv(a) * smv(b);
        lat = int'(a[1:0]) + 2;
`else
        r     = 0;
        m.err = 1'b1;
`endif
      end
    endcase
    m.res  = r[RW-1:0];
    m.at_e = acc_e + lat;
    return m;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_result"}, int'(rsp_result), 0);
    chk({tag, "_rsp_err"}, int'(rsp_err), 0);
  endtask

  // Monitor: pops the scoreboard on each new response.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (hs_pend) begin
        hs_pend = 0;
        active  = 0;
        chk("post_hs_req_ready", int'(req_ready), 1);
        chk("post_hs_rsp_valid", int'(rsp_valid), 0);
      end else if (rsp_valid) begin
        if (!active) begin
          active = 1;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_rsp: got %0h expected none", rsp_result);
            cur.res = rsp_result;
            cur.err = rsp_err;
          end else begin
            cur = exp_q.pop_front();
            chk("rsp_latency_edge", e, cur.at_e);
            chk("rsp_result", int'(rsp_result), int'(cur.res));
            chk("rsp_err", int'(rsp_err), int'(cur.err));
          end
        end else begin
          chk("stable_result", int'(rsp_result), int'(cur.res));
          chk("stable_err", int'(rsp_err), int'(cur.err));
        end
        chk("busy_req_ready", int'(req_ready), 0);
        if (rsp_ready) hs_pend = 1;
      end
    end
  end

  // Driver: real requests while idle, ignored junk while busy.
  initial begin
    int    n_rand;
    int    stall;
    int    rst_cd;
    int    cyc;
    int    drain;
    bit    v;
    dreq_t d;
    dir.push_back('{2'b00, 3'b011, 3'b111, 0, 0});
    dir.push_back('{2'b01, 3'b011, 3'b111, 0, 0});
    dir.push_back('{2'b11, 3'b010, 3'b000, 0, 0});
    dir.push_back('{2'b00, 3'b100, 3'b100, 0, 0});
    dir.push_back('{2'b10, 3'b111, 3'b011, 0, 0});
    dir.push_back('{2'b10, 3'b100, 3'b111, 0, 0});
    dir.push_back('{2'b10, 3'b011, 3'b011, 0, 0});
    dir.push_back('{2'b00, 3'b001, 3'b010, 4, 0});
    dir.push_back('{2'b10, 3'b011, 3'b001, 0, 1});
    dir.push_back('{2'b00, 3'b010, 3'b001, 0, 0});
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    n_rand = 0;
    stall = 0;
    rst_cd = 0;
    cyc = 0;
    while ((dir.size() != 0) || (n_rand < NRAND)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 20000) begin
        errors++;
        checks++;
        $display("FAIL stim_timeout: got %0d cycles expected < 20000", cyc);
        break;
      end
      if (rst) begin
        rst = 1'b0;
        chk_reset_outputs("midop_reset");
        exp_q.delete();
      end else if (rst_cd > 0) begin
        rst_cd--;
        if (rst_cd == 0) rst = 1'b1;
      end
      if (stall > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) stall--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      if (req_ready && !rst) begin
        if (dir.size() != 0) begin
          d = dir.pop_front();
          v = 1'b1;
        end else begin
          d.op = 2'($urandom_range(0, 3));
          d.a = 3'($urandom_range(0, 7));
          d.b = 3'($urandom_range(0, 7));
          d.stall = 0;
          d.do_rst = 0;
          v = ($urandom_range(0, 3) != 0);
          if (v) n_rand++;
        end
        req_valid = v;
        req_op = d.op;
        req_a = d.a;
        req_b = d.b;
        if (v) begin
          exp_q.push_back(model(d.op, d.a, d.b, e + 1));
          if (d.stall > 0) stall = d.stall;
          if (d.do_rst) rst_cd = 2;
        end
      end else begin
        req_valid = ($urandom_range(0, 1) != 0);
        req_op = 2'($urandom_range(0, 3));
        req_a = 3'($urandom_range(0, 7));
        req_b = 3'($urandom_range(0, 7));
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain = 0;
    while (((exp_q.size() != 0) || active || hs_pend) && (drain < 200)) begin
      @(posedge clk);
      #1;
      drain++;
    end
    if (drain >= 200) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the signed calculator datapath. Accepts one operation per valid/ready request on sign-magnitude operands and executes ADD, SUB, NEG or MUL. MUL is done by repeated addition. The result is returned as two's complement on a valid/ready response channel. The block sits between the operator/keypad front end and the result display logic, and serialises all arithmetic requests.

## Interface
- OPW, 3, operand width in sign-magnitude: bit OPW-1 is the sign, the rest is magnitude.
- RW, 2*OPW-1, result width, two's complement. Must not be overridden.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation code: 00 ADD (A+B), 01 SUB (A-B), 10 MUL (A*B), 11 NEG (-A, B ignored).
- req_a  in  OPW  operand A, sign-magnitude.
- req_b  in  OPW  operand B, sign-magnitude.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  RW  result, two's complement.
- rsp_err  out  1  operation not supported in this build.

## Operation
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch op, A, B and go to EXEC, or to MUL if op=10 and multiply is compiled in.
  - EXEC: go to DONE.
  - MUL: repeated-add loop (below), then go to DONE.
  - DONE: hold the response; go to IDLE on rsp_ready.
- Operand conversion: sign-magnitude to two's complement, sign-extended to RW bits. Negative zero (sign=1, magnitude=0) is treated as +0 everywhere.
- EXEC computes one of:
  - ADD: A+B.
  - SUB: A-B.
  - NEG: 0-A.
  - No overflow is possible: |result| ≤ 2*(2^(OPW-1)-1), which fits in RW bits.
- MUL loop:
  - On accept: acc=0, cnt=|A|, sgn=A.sign XOR B.sign.
  - Each MUL cycle with cnt≠0: acc += |B|, cnt -= 1.
  - When cnt=0: result = sgn ? -acc : acc, then go to DONE.
  - A zero product is always +0, i.e. RW'b0.
- rsp_result and rsp_err are registered. They stay stable while rsp_valid=1 and rsp_ready=0.
- A request is accepted only in IDLE. req_valid in any other state is ignored (not queued).
- DONE→IDLE on the rsp handshake. The earliest next accept is the following cycle: no same-cycle turnaround.
- Reset, including mid-operation:
  - Next state is IDLE; the in-flight operation is discarded.
  - rsp_valid=0, rsp_result=0, rsp_err=0, req_ready=1.
  - acc, cnt and sgn are cleared.

## Timing
- Edge numbering: the accept edge is edge 0.
- ADD, SUB, NEG: rsp_valid=1 after edge 2.
- MUL: rsp_valid=1 after edge |A|+2. Worst case at OPW=3 is 5.
- req_ready is deasserted from edge 0 until the edge of the rsp handshake, inclusive.
- There is no combinational path from any input to any output except req_ready. req_ready is a decode of the state register.

## Configuration
- Macro CALC_CTRL_MUL_EN.
- Defined: MUL is supported as described above.
- Undefined:
  - The MUL state and the acc/cnt loop logic are not built.
  - op 10 goes through EXEC with ADD latency and returns rsp_result=0, rsp_err=1.
  - rsp_err is constant 0 for all other ops.

## Structure
- Shared package calc_pkg holds:
  - the op code constants;
  - the state enum (IDLE, EXEC, MUL, DONE);
  - default OPW and RW;
  - function sm_to_tc (sign-magnitude to RW-bit two's complement, folding -0 to +0).
- One sub-module is natural: calc_mul_seq, the repeated-add loop (acc, cnt, sgn, done pulse). It is instantiated only under CALC_CTRL_MUL_EN.
- The FSM, the add/sub path and the response register stay in calc_ctrl.

## Test plan
- ADD A=011 (+3), B=111 (-3) -> rsp_result=00000 after edge 2; SUB with the same operands -> 00110 (+6).
- NEG A=010 (+2) -> 11110 (-2); ADD A=100 (-0), B=100 (-0) -> 00000.
- MUL A=111 (-3), B=011 (+3) -> 10111 (-9), rsp_valid rising after edge 5. MUL A=100, B=111 -> 00000 after edge 2.
- Backpressure: hold rsp_ready=0 for 4 cycles with req_valid=1 and new operands -> rsp_result stable, req_ready=0, new request ignored. Raise rsp_ready -> req_ready=1 the next cycle.
- rst pulsed during the MUL loop (cnt=2) -> the next cycle shows rsp_valid=0, rsp_result=0, req_ready=1, and a following ADD completes normally.
- Build without CALC_CTRL_MUL_EN: MUL A=011, B=011 -> rsp_result=0, rsp_err=1 after edge 2; ADD -> rsp_err=0.
